// File: rtl/twi_cfg_pkg.sv
// rtl/twi_cfg_pkg.sv - shared types and slot waveform constants for the TWI config sequencer
package twi_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_REG,
        ST_DATA,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_END_OK,
        ST_END_ERR
    } twi_state_e;

    typedef enum logic [1:0] {
        BYTE_ADDR,
        BYTE_REG,
        BYTE_DATA
    } byte_sel_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Bit n of each pattern is the line level during quarter n of the slot.
    localparam logic [3:0] START_SDA = 4'b0011;
    localparam logic [3:0] START_SCL = 4'b0111;
    localparam logic [3:0] DATA_SCL  = 4'b0110;
    localparam logic [3:0] ACK_SDA   = 4'b1111;
    localparam logic [3:0] ACK_SCL   = 4'b0110;
    localparam logic [3:0] STOP_SDA  = 4'b1100;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] LINE_IDLE = 4'b1111;

    localparam int SLOTS_PER_ENTRY = 30;

endpackage

// File: rtl/twi_quarter_timer.sv
// rtl/twi_quarter_timer.sv - quarter-bit prescaler producing quarter index and slot strobes
module twi_quarter_timer
    import twi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic       qtr_stb,
    output logic       slot_start,
    output logic       slot_end,
    output logic [1:0] quarter
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    quarter_q, quarter_d;

    always_comb begin
        qtr_stb    = en && (cnt_q == CNT_LAST);
        slot_end   = qtr_stb && (quarter_q == Q3);
        slot_start = en && (cnt_q == '0) && (quarter_q == Q0);
        cnt_d      = cnt_q;
        quarter_d  = quarter_q;
        if (!en || clr) begin
            cnt_d     = '0;
            quarter_d = Q0;
        end else if (qtr_stb) begin
            cnt_d     = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

    assign quarter = quarter_q;

endmodule

// File: rtl/twi_config_sequencer.sv
// rtl/twi_config_sequencer.sv - autonomous I2C master writing a {reg,value} table to one slave
module twi_config_sequencer
    import twi_cfg_pkg::*;
#(
    parameter int         CLK_DIV  = 125,
    parameter int         NUM_REGS = 16,
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter int         IDX_W    = 4
) (
    input  logic             i_system_clk,
    input  logic             i_system_rst,
    input  logic             i_start,
    output logic [IDX_W-1:0] o_cfg_index,
    input  logic [15:0]      i_cfg_data,
    input  logic             i_twi_sda,
    output logic             o_twi_sda,
    output logic             o_twi_scl,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [IDX_W-1:0] o_err_index
);

    localparam logic [7:0]       ADDR_BYTE = {DEV_ADDR, 1'b0};
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);

    twi_state_e       state_q, state_d;
    byte_sel_e        sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic [2:0]       bit_q, bit_d;
    logic [15:0]      entry_q, entry_d;
    logic             nack_q, nack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             sda_q, sda_d;
    logic             scl_q, scl_d;

    logic       qtr_stb, slot_start, slot_end, slot_clr;
    logic [1:0] quarter;
    logic       tx_bit;
    logic [3:0] sda_pat, scl_pat;

    assign slot_clr = (state_q == ST_IDLE) || (state_q == ST_END_OK) || (state_q == ST_END_ERR);

    twi_quarter_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .clk       (i_system_clk),
        .rst_n     (i_system_rst),
        .en        (busy_q),
        .clr       (slot_clr),
        .qtr_stb   (qtr_stb),
        .slot_start(slot_start),
        .slot_end  (slot_end),
        .quarter   (quarter)
    );

    // REG and DATA bytes leave MSB first from the top of the latched entry.
    always_comb begin
        tx_bit = (state_q == ST_ADDR) ? ADDR_BYTE[bit_q] : entry_q[15];
        case (state_q)
            ST_START: begin
                sda_pat = START_SDA;
                scl_pat = START_SCL;
            end
            ST_ADDR, ST_REG, ST_DATA: begin
                sda_pat = {4{tx_bit}};
                scl_pat = DATA_SCL;
            end
            ST_ACK: begin
                sda_pat = ACK_SDA;
                scl_pat = ACK_SCL;
            end
            ST_STOP: begin
                sda_pat = STOP_SDA;
                scl_pat = STOP_SCL;
            end
            default: begin
                sda_pat = LINE_IDLE;
                scl_pat = LINE_IDLE;
            end
        endcase
        sda_d = sda_pat[quarter];
        scl_d = scl_pat[quarter];
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        bit_d     = bit_q;
        entry_d   = entry_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    idx_d   = '0;
                    nack_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (slot_start) begin
                    entry_d = i_cfg_data;
                end
                if (slot_end) begin
                    state_d = ST_ADDR;
                    sel_d   = BYTE_ADDR;
                    bit_d   = 3'd7;
                end
            end
            ST_ADDR, ST_REG, ST_DATA: begin
                if (slot_end) begin
                    if (state_q != ST_ADDR) begin
                        entry_d = {entry_q[14:0], 1'b0};
                    end
                    if (bit_q == 3'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                // Sample on the last cycle of q2, while SCL is still high.
                if (qtr_stb && (quarter == Q2)) begin
                    nack_d = i_twi_sda;
                end
                if (slot_end) begin
                    bit_d = 3'd7;
                    if (nack_q) begin
                        state_d = ST_STOP;
                    end else begin
                        case (sel_q)
                            BYTE_ADDR: begin
                                state_d = ST_REG;
                                sel_d   = BYTE_REG;
                            end
                            BYTE_REG: begin
                                state_d = ST_DATA;
                                sel_d   = BYTE_DATA;
                            end
                            default: state_d = ST_STOP;
                        endcase
                    end
                end
            end
            ST_STOP: begin
                if (slot_end) begin
                    state_d = nack_q ? ST_END_ERR : ST_GAP;
                end
            end
            ST_GAP: begin
                if (slot_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_END_OK;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        nack_d  = 1'b0;
                        state_d = ST_START;
                    end
                end
            end
            ST_END_OK: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            ST_END_ERR: begin
                error_d   = 1'b1;
                err_idx_d = idx_q;
                busy_d    = 1'b0;
                idx_d     = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_system_clk or negedge i_system_rst) begin
        if (!i_system_rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= BYTE_ADDR;
            idx_q     <= '0;
            err_idx_q <= '0;
            bit_q     <= 3'd7;
            entry_q   <= '0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            bit_q     <= bit_d;
            entry_q   <= entry_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
        end
    end

    assign o_cfg_index = idx_q;
    assign o_err_index = err_idx_q;
    assign o_twi_sda   = sda_q;
    assign o_twi_scl   = scl_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_twi_config_sequencer.sv
// tb/tb_twi_config_sequencer.sv - directed bench with I2C slave model and waveform reference
module tb_twi_config_sequencer;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [3:0]  o_cfg_index;
    logic [15:0] i_cfg_data;
    logic        i_twi_sda;
    logic        o_twi_sda;
    logic        o_twi_scl;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [3:0]  o_err_index;

    logic [15:0] tbl0, tbl1;
    logic        slv_sda;

    int tests_run;
    int tests_failed;

    // Stimulus-side controls (written only by the main initial block)
    logic       mon_clr;
    logic       wave_on;
    logic       nack_on;
    int         nack_frame;
    int         nack_byte;
    logic [7:0] exp_b [0:5];

    // Monitor results (written only by the monitor)
    int         n;
    int         wave_err;
    int         done_cnt, done_at, fall_at, stop_at;
    int         starts, stops, nacks;
    int         nbytes, frame, bitn, byte_in_frame;
    logic [7:0] shreg;
    logic [7:0] mon_bytes [0:15];
    logic       scl_p, sda_p, busy_p, mon_sda, mon_scl;

    assign i_cfg_data = (o_cfg_index == 4'd0) ? tbl0 : (o_cfg_index == 4'd1) ? tbl1 : 16'hDEAD;
    assign i_twi_sda  = o_twi_sda & slv_sda;

    twi_config_sequencer #(
        .CLK_DIV (4),
        .NUM_REGS(2),
        .DEV_ADDR(7'h76),
        .IDX_W   (4)
    ) dut (
        .i_system_clk(clk),
        .i_system_rst(rst_n),
        .i_start     (i_start),
        .o_cfg_index (o_cfg_index),
        .i_cfg_data  (i_cfg_data),
        .i_twi_sda   (i_twi_sda),
        .o_twi_sda   (o_twi_sda),
        .o_twi_scl   (o_twi_scl),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_err_index (o_err_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {sda,scl} n cycles after busy was first seen high (CLK_DIV=4, 2 entries, all ACKed).
    function automatic logic [1:0] exp_wave(input int nn);
        int m, slot, e, s, q, b, pos;
        logic [7:0] byt;
        if (nn == 0) return 2'b11;
        m = nn - 1;
        if (m >= 960) return 2'b11;
        slot = m / 16;
        e    = slot / 30;
        s    = slot % 30;
        q    = (m % 16) / 4;
        if (s == 0) return {q < 2, q < 3};
        if (s <= 27) begin
            b   = (s - 1) / 9;
            pos = (s - 1) % 9;
            if (pos == 8) return {1'b1, (q == 1) || (q == 2)};
            byt = exp_b[e*3 + b];
            return {byt[7-pos], (q == 1) || (q == 2)};
        end
        if (s == 28) return {q >= 2, q >= 1};
        return 2'b11;
    endfunction

    always @(negedge clk) begin
        if (mon_clr) begin
            n = 100000; wave_err = 0; done_cnt = 0; done_at = -1; fall_at = -1; stop_at = -1;
            starts = 0; stops = 0; nacks = 0; nbytes = 0; frame = -1; bitn = 0;
            byte_in_frame = 0; shreg = 8'h00; slv_sda = 1'b1;
            scl_p = o_twi_scl; sda_p = i_twi_sda; busy_p = o_busy;
        end else begin
            mon_sda = o_twi_sda & slv_sda;
            mon_scl = o_twi_scl;
            if (o_busy && !busy_p) n = 0;
            else if (n < 100000) n++;
            if (wave_on && n <= 975 && ({o_twi_sda, o_twi_scl} !== exp_wave(n))) wave_err++;
            if (o_done) begin
                done_cnt++;
                done_at = n;
            end
            if (!o_busy && busy_p) fall_at = n;
            if (mon_scl && scl_p) begin
                if (sda_p && !mon_sda) begin
                    starts++; frame++; bitn = 0; byte_in_frame = 0;
                end else if (!sda_p && mon_sda) begin
                    stops++; stop_at = n;
                end
            end else if (mon_scl && !scl_p) begin
                if (bitn < 8) begin
                    shreg = {shreg[6:0], mon_sda};
                    bitn++;
                    if (bitn == 8) begin
                        if (nbytes < 16) mon_bytes[nbytes] = shreg;
                        nbytes++;
                        byte_in_frame++;
                    end
                end else begin
                    if (mon_sda) nacks++;
                    bitn = 0;
                end
            end else if (!mon_scl && scl_p) begin
                if (bitn == 8)
                    slv_sda = (nack_on && frame == nack_frame && byte_in_frame - 1 == nack_byte) ? 1'b1 : 1'b0;
                else
                    slv_sda = 1'b1;
            end
            scl_p  = mon_scl;
            sda_p  = mon_sda;
            busy_p = o_busy;
        end
    end

    int tb_n;

    task automatic clear_mon();
        @(negedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        tb_n = 0;
    endtask

    task automatic step_to(input int t);
        while (tb_n < t) begin
            @(negedge clk);
            tb_n++;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        chk({tag, "_timeout"}, o_busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input int count);
        chk({tag, "_nbytes"}, nbytes, count);
        for (int i = 0; i < count && i < 16; i++)
            chk($sformatf("%s_byte%0d", tag, i), mon_bytes[i], exp_b[i]);
    endtask

    task automatic check_ok_run(input string tag);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_at"}, done_at, 961);
        chk({tag, "_wave_err"}, wave_err, 0);
        chk({tag, "_starts"}, starts, 2);
        chk({tag, "_stops"}, stops, 2);
        check_bytes(tag, 6);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; i_start = 1'b0; mon_clr = 1'b1; wave_on = 1'b0; nack_on = 1'b0;
        nack_frame = 0; nack_byte = 0; tb_n = 0; slv_sda = 1'b1;
        tbl0 = 16'h49C0; tbl1 = 16'h2109;
        exp_b[0] = 8'hEC; exp_b[1] = 8'h49; exp_b[2] = 8'hC0;
        exp_b[3] = 8'hEC; exp_b[4] = 8'h21; exp_b[5] = 8'h09;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sda", o_twi_sda, 1'b1);
        chk("rst_scl", o_twi_scl, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_error", o_error, 1'b0);
        chk("rst_err_index", o_err_index, 4'd0);
        chk("rst_cfg_index", o_cfg_index, 4'd0);

        // Normal two-entry run
        wave_on = 1'b1;
        clear_mon();
        pulse_start();
        wait_idle("ok");
        check_ok_run("ok");
        chk("ok_cfg_index", o_cfg_index, 4'd0);
        chk("ok_nacks", nacks, 0);

        // NACK on REG byte of entry 1
        wave_on = 1'b0; nack_on = 1'b1; nack_frame = 1; nack_byte = 1;
        clear_mon();
        pulse_start();
        wait_idle("nack");
        chk("nack_error", o_error, 1'b1);
        chk("nack_err_index", o_err_index, 4'd1);
        chk("nack_done_cnt", done_cnt, 0);
        chk("nack_nacks", nacks, 1);
        chk("nack_stop_at", stop_at, 793);
        chk("nack_busy_fall", fall_at, 801);
        chk("nack_stops", stops, 2);
        chk("nack_sda_idle", o_twi_sda, 1'b1);
        chk("nack_scl_idle", o_twi_scl, 1'b1);
        check_bytes("nack", 5);

        // Restart after error clears the flag one cycle after the start
        nack_on = 1'b0; wave_on = 1'b1;
        clear_mon();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        tb_n = 0;
        chk("restart_err_clr", o_error, 1'b0);
        chk("restart_busy", o_busy, 1'b1);
        wait_idle("restart");
        check_ok_run("restart");
        chk("restart_error", o_error, 1'b0);

        // Extra starts while busy, including the END_OK cycle, change nothing
        clear_mon();
        pulse_start();
        foreach (exp_b[k]) begin end
        for (int j = 0; j < 4; j++) begin
            step_to((j == 0) ? 100 : (j == 1) ? 480 : (j == 2) ? 700 : 960);
            i_start = 1'b1;
            @(negedge clk);
            tb_n++;
            i_start = 1'b0;
        end
        wait_idle("rep");
        check_ok_run("rep");
        chk("rep_no_restart", o_busy, 1'b0);

        // Asynchronous reset in the middle of entry 0's DATA byte
        wave_on = 1'b0;
        clear_mon();
        pulse_start();
        step_to(350);
        rst_n = 1'b0;
        #1;
        chk("arst_sda", o_twi_sda, 1'b1);
        chk("arst_scl", o_twi_scl, 1'b1);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_cfg_index", o_cfg_index, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wave_on = 1'b1;
        clear_mon();
        pulse_start();
        wait_idle("post_rst");
        check_ok_run("post_rst");

        // Table changes mid-entry are ignored
        clear_mon();
        pulse_start();
        step_to(50);
        tbl0 = 16'hFFFF;
        step_to(580);
        tbl1 = 16'h0000;
        wait_idle("latch");
        check_ok_run("latch");
        tbl0 = 16'h49C0; tbl1 = 16'h2109;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
